cla_requester32: RTL and testbench
==================================

Name: cla_requester32

Overview:
- Initiator side of the 16-bit CLA adder en/ready handshake.
- Accepts a 32-bit add/subtract request from the datapath controller and runs it as two 16-bit adder transactions, low half then high half, chaining the carry between them.
- Latches operands, sequences `add_en`, captures results on `add_ready`, and reports result, flags and completion.
- Bounds every adder wait with a timeout so the CPU controller can never hang.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles `add_en` is held high per pass without `add_ready` before the operation is aborted.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request strobe, sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a-b
- a  in  32  operand A
- b  in  32  operand B
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- result  out  32  sum/difference, held until next accepted start
- carry  out  1  carry out of bit 31 (for sub: 1 = no borrow)
- overflow  out  1  signed overflow of the 32-bit operation
- error  out  1  set with done on timeout, held until next accepted start
- add_en  out  1  adder enable
- add_c_in  out  1  adder carry-in / B-invert control
- add_a  out  16  adder operand A
- add_b  out  16  adder operand B (pre-adder)
- add_out  in  16  adder sum, valid when add_ready=1
- add_c_out  in  1  adder carry out, valid when add_ready=1
- add_ready  in  1  adder result valid; cleared by adder after add_en=0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy, done, error, carry, overflow, add_en, add_c_in = 0.
  - result, add_a, add_b = 0.
  - Counter and latched operands cleared.
  - Reset mid-operation abandons the transaction; add_en drops immediately.
- Adder semantics relied on:
  - The adder computes add_a + (add_b XOR {16{add_c_in}}) + add_c_in.
  - So the requester drives add_b = b_eff XOR {16{c}} and add_c_in = c, where b_eff = b_half XOR {16{sub}} and c = carry into the pass.
  - Low pass: c = sub, so add_b = b[15:0].
  - High pass: c = captured low carry, add_b = b[31:16] XOR {16{sub}} XOR {16{c}}.
- States:
  - IDLE: busy=0, add_en=0. If start=1, latch a, b, sub; clear error, carry, overflow; go to LO_REQ.
  - LO_REQ: add_en=1, add_a=a[15:0], add_b/add_c_in as above; counter increments each cycle.
    - On add_ready=1: capture add_out into result[15:0] and add_c_out into c_lo; go to LO_REL.
    - If counter reaches TIMEOUT_CYCLES without add_ready: go to ABORT.
  - LO_REL: add_en=0, counter cleared. Stay while add_ready=1; advance to HI_REQ once add_ready=0. Minimum 1 cycle.
  - HI_REQ: as LO_REQ but with high halves and c=c_lo.
    - On add_ready=1: capture result[31:16] and carry=add_c_out; compute overflow; go to HI_REL.
    - Timeout: go to ABORT.
  - HI_REL: add_en=0. Once add_ready=0, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
  - ABORT: add_en=0, result=0, carry=0, overflow=0, error=1, done=1 for one cycle; next state IDLE.
- Operand stability: add_a, add_b and add_c_in are constant for the whole time add_en is high in a pass.
- Handshake rule: add_en never rises in a cycle where add_ready is sampled 1.
- Overflow: overflow = (a[31] == b_eff[31]) && (result[31] != a[31]), with b_eff[31] = b[31]^sub.
- start ignored while busy, in DONE and in ABORT; the latched operands are unaffected by input changes.
- start coincident with the done pulse is ignored; start is accepted again from the next IDLE cycle.
- Nominal latency from start to done: 2 cycles per adder response plus 2 release cycles plus 1.
- Timeout counter counts add_en-high cycles per pass only; it is reset entering each REQ state.

Test Plan:
- Add, carry chain: a=0x0000FFFF, b=0x00000001, sub=0 → result=0x00010000, carry=0, overflow=0, error=0; c_lo=1 observed in high pass.
- Subtract, borrow: a=0x00000000, b=0x00000001, sub=1 → result=0xFFFFFFFF, carry=0, overflow=0; add_b low pass=0x0001, add_c_in=1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 → result=0x80000000, overflow=1. Then a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, overflow=1, carry=1.
- Timeout: adder model never raises add_ready → after TIMEOUT_CYCLES add_en falls; done and error pulse/set together; result=0; busy=0 the following cycle.
- Handshake protocol:
  - Adder model holds add_ready high 3 cycles after add_en falls → requester stays in the release state with add_en=0 until add_ready=0.
  - start pulses while busy are ignored; result is unchanged by them.
- Reset mid-op: assert reset_n=0 during HI_REQ → add_en, busy, done and result go to 0 asynchronously. After release, a fresh start with a=5, b=3, sub=1 → result=2, carry=1.

Source files
------------

// File: rtl/cla_requester32.sv
// Purpose : runs a 32-bit add/sub as two chained 16-bit passes on an en/ready CLA adder.
// Latency : start -> done = 2 cycles per adder response + 2 release cycles + 1.
// Backpress: start accepted only in IDLE; each add_en pass aborts after TIMEOUT_CYCLES without add_ready.
// Ports   : clk/reset_n; start/sub/a/b request; busy/done/result/carry/overflow/error status;
//           add_en/add_c_in/add_a/add_b drive the adder, add_out/add_c_out/add_ready return from it.
module cla_requester32 #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        error,
  output logic        add_en,
  output logic        add_c_in,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_out,
  input  logic        add_c_out,
  input  logic        add_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LO_REQ, S_LO_REL, S_HI_REQ, S_HI_REL, S_DONE, S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sub_q, sub_d, c_lo_q, c_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               carry_q, carry_d, overflow_q, overflow_d, error_q, error_d;
  logic               add_en_q, add_en_d, add_c_in_q, add_c_in_d;
  logic [15:0]        add_a_q, add_a_d, add_b_q, add_b_d;
  logic               timeout_hit;

  // Last add_en-high cycle of the pass: counter holds cycles already spent in REQ.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    c_lo_d     = c_lo_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    add_en_d   = add_en_q;
    add_c_in_d = add_c_in_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        add_en_d = 1'b0;
        // Holding off while add_ready is still high keeps add_en from rising
        // into a stale response left over from an aborted pass.
        if (start && !add_ready) begin
          a_d        = a;
          b_d        = b;
          sub_d      = sub;
          error_d    = 1'b0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          add_en_d   = 1'b1;
          add_a_d    = a[15:0];
          // b_eff ^ {16{c}} with c = sub cancels back to the raw low half of b.
          add_b_d    = b[15:0];
          add_c_in_d = sub;
          state_d    = S_LO_REQ;
        end
      end

      S_LO_REQ: begin
        if (add_ready) begin
          result_d = {result_q[31:16], add_out};
          c_lo_d   = add_c_out;
          add_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_LO_REL;
        end else if (timeout_hit) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_LO_REL: begin
        cnt_d = '0;
        if (!add_ready) begin
          add_en_d   = 1'b1;
          add_a_d    = a_q[31:16];
          add_b_d    = b_q[31:16] ^ {16{sub_q ^ c_lo_q}};
          add_c_in_d = c_lo_q;
          state_d    = S_HI_REQ;
        end
      end

      S_HI_REQ: begin
        if (add_ready) begin
          result_d   = {add_out, result_q[15:0]};
          carry_d    = add_c_out;
          overflow_d = (a_q[31] == (b_q[31] ^ sub_q)) && (add_out[15] != a_q[31]);
          add_en_d   = 1'b0;
          cnt_d      = '0;
          state_d    = S_HI_REL;
        end else if (timeout_hit) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HI_REL: begin
        if (!add_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort outputs are set on the transition so they appear in the ABORT cycle.
    if (state_d == S_ABORT && state_q != S_ABORT) begin
      add_en_d   = 1'b0;
      cnt_d      = '0;
      result_d   = '0;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      error_d    = 1'b1;
      done_d     = 1'b1;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      c_lo_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      add_en_q   <= 1'b0;
      add_c_in_q <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      c_lo_q     <= c_lo_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
      add_en_q   <= add_en_d;
      add_c_in_q <= add_c_in_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign error    = error_q;
  assign add_en   = add_en_q;
  assign add_c_in = add_c_in_q;
  assign add_a    = add_a_q;
  assign add_b    = add_b_q;

endmodule

// File: tb/tb_cla_requester32.sv
// Purpose : drives cla_requester32 against a behavioural 16-bit adder and a 32-bit arithmetic model.
// Latency : expected results are queued at start and consumed when done pulses.
// Backpress: adder response delay, ready hold time and no-response mode are varied per operation.
module tb_cla_requester32;

  localparam int TIMEOUT_CYCLES = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, sub;
  logic [31:0] a, b;
  logic        busy, done, carry, overflow, error;
  logic [31:0] result;
  logic        add_en, add_c_in;
  logic [15:0] add_a, add_b;
  logic [15:0] add_out;
  logic        add_c_out, add_ready;

  cla_requester32 #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .overflow(overflow),
    .error(error), .add_en(add_en), .add_c_in(add_c_in), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .add_c_out(add_c_out), .add_ready(add_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        ov;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Operation currently in flight, for the adder-port operand checks.
  logic [31:0] cur_a, cur_b;
  logic        cur_sub;

  // Behavioural adder configuration.
  int resp_delay  = 1;
  int hold_extra  = 0;
  bit never_ready = 0;

  // ---------------- adder model: sum = A + (B ^ {16{cin}}) + cin ----------------
  initial begin : adder_model
    int wait_cnt, hold_cnt;
    logic [16:0] s17;
    wait_cnt = 0; hold_cnt = 0;
    add_ready = 1'b0; add_out = '0; add_c_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        add_ready = 1'b0; wait_cnt = 0; hold_cnt = 0;
      end else if (!add_ready) begin
        if (add_en && !never_ready) begin
          wait_cnt++;
          if (wait_cnt >= resp_delay) begin
            s17 = {1'b0, add_a} + {1'b0, add_b ^ {16{add_c_in}}} + {16'd0, add_c_in};
            add_out = s17[15:0]; add_c_out = s17[16];
            add_ready = 1'b1; wait_cnt = 0; hold_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end else if (!add_en) begin
        if (hold_cnt >= hold_extra) begin add_ready = 1'b0; hold_cnt = 0; end
        else hold_cnt++;
      end
    end
  end

  // ---------------- monitor: protocol checks and scoreboard ----------------
  initial begin : monitor
    logic        en_p, rdy_p, cin_p;
    logic [15:0] a_p, b_p;
    int          pass, en_run;
    logic [16:0] lo17;
    logic        c_lo;
    exp_t        e;
    en_p = 0; rdy_p = 0; cin_p = 0; a_p = '0; b_p = '0; pass = 0; en_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        en_p = 0; rdy_p = 0; pass = 0; en_run = 0;
      end else begin
        if (add_en && !en_p) begin
          check("en_rise_ready_low", 64'(rdy_p), 64'(0));
          if (pass == 0) begin
            check("lo_add_a", 64'(add_a), 64'(cur_a[15:0]));
            check("lo_add_b", 64'(add_b), 64'(cur_b[15:0]));
            check("lo_c_in", 64'(add_c_in), 64'(cur_sub));
          end else begin
            lo17 = {1'b0, cur_a[15:0]} + {1'b0, cur_b[15:0] ^ {16{cur_sub}}} + {16'd0, cur_sub};
            c_lo = lo17[16];
            check("hi_add_a", 64'(add_a), 64'(cur_a[31:16]));
            check("hi_add_b", 64'(add_b), 64'(cur_b[31:16] ^ {16{cur_sub}} ^ {16{c_lo}}));
            check("hi_c_in", 64'(add_c_in), 64'(c_lo));
          end
          pass++;
        end
        if (add_en && en_p)
          check("operands_stable", 64'({add_a, add_b, add_c_in}), 64'({a_p, b_p, cin_p}));
        if (add_en) en_run++;
        else if (en_p) begin
          if (never_ready) check("timeout_en_len", 64'(en_run), 64'(TIMEOUT_CYCLES));
          en_run = 0;
        end
        if (done) begin
          check("busy_low_at_done", 64'(busy), 64'(0));
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("carry", 64'(carry), 64'(e.c));
            check("overflow", 64'(overflow), 64'(e.ov));
            check("error", 64'(error), 64'(e.err));
          end
          pass = 0;
        end
        en_p = add_en; rdy_p = add_ready; a_p = add_a; b_p = add_b; cin_p = add_c_in;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                        input bit tmo, input bit noise);
    exp_t        e;
    logic [32:0] full;
    bit          got;
    full = {1'b0, ta} + {1'b0, tbv ^ {32{ts}}} + {32'd0, ts};
    if (tmo) begin
      e.res = '0; e.c = 1'b0; e.ov = 1'b0; e.err = 1'b1;
    end else begin
      e.res = full[31:0];
      e.c   = full[32];
      e.ov  = (ta[31] == (tbv[31] ^ ts)) && (full[31] != ta[31]);
      e.err = 1'b0;
    end
    @(posedge clk); #1;
    a = ta; b = tbv; sub = ts; start = 1'b1;
    cur_a = ta; cur_b = tbv; cur_sub = ts;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (done) got = 1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL done_wait: got no done expected done within 200 cycles at %0t", $time);
    end
    // A start held during the done cycle must be ignored.
    if (noise) begin start = 1'b1; a = $urandom; b = $urandom; end
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done", 64'(busy), 64'(0));
    check("error_held", 64'(error), 64'(tmo));
    check("result_held", 64'(result), 64'(e.res));
  endtask

  initial begin : stim
    int rises;
    logic en_prev;
    logic [31:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    cur_a = '0; cur_b = '0; cur_sub = 1'b0;
    @(posedge clk); #2;
    check("rst_outputs", 64'({busy, done, error, carry, overflow, add_en, add_c_in}), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_add_ab", 64'({add_a, add_b}), 64'(0));
    @(posedge clk); #3; reset_n = 1'b1;

    // Directed cases.
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 0, 0);
    run_op(32'h00000000, 32'h00000001, 1'b1, 0, 0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 0, 0);

    never_ready = 1;
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1, 0);
    never_ready = 0;

    hold_extra = 3; resp_delay = 2;
    run_op(32'hDEADBEEF, 32'h0F0F0F0F, 1'b0, 0, 1);
    run_op(32'h00010000, 32'h00000001, 1'b1, 0, 1);
    hold_extra = 0; resp_delay = 1;

    // Reset while the high pass is outstanding.
    resp_delay = 3;
    @(posedge clk); #1;
    a = 32'h0001FFFF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
    cur_a = a; cur_b = b; cur_sub = sub;
    @(posedge clk); #1;
    start = 1'b0;
    rises = 1; en_prev = add_en;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(posedge clk); #1;
      if (add_en && !en_prev) rises++;
      en_prev = add_en;
    end
    check("rst_reached_hi_pass", 64'(rises), 64'(2));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_add_en", 64'(add_en), 64'(0));
    check("midrst_busy_done", 64'({busy, done}), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;
    resp_delay = 1;
    run_op(32'd5, 32'd3, 1'b1, 0, 0);

    // Randomized operations with varied adder timing.
    for (int n = 0; n < 40; n++) begin
      resp_delay = $urandom_range(1, 4);
      hold_extra = $urandom_range(0, 3);
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra[15:0] = 16'hFFFF;
        1: begin ra[31] = ~rb[31]; rb[30:0] = 31'h7FFFFFFF; end
        2: rb = ra;
        default: ;
      endcase
      never_ready = ($urandom_range(0, 9) == 0);
      run_op(ra, rb, 1'($urandom_range(0, 1)), never_ready, 1'($urandom_range(0, 1)));
      never_ready = 0;
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
